miner_nonce_dispatcher: RTL
===========================

MINER_NONCE_DISPATCHER -- requirements
Module: miner_nonce_dispatcher

Interface
REQ-001 Parameter CORES, default 4, number of hashing-core lanes (1..16).
REQ-002 Parameter NONCE_W, default 32, nonce width in bits (8..32).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse; begins a search over [range_lo, range_hi].
REQ-006 abort  input  1  level; stops the search; has priority over start and found.
REQ-007 found  input  1  one-cycle pulse from the checker; stops the search with success.
REQ-008 range_lo  input  NONCE_W  first nonce, sampled on an accepted start.
REQ-009 range_hi  input  NONCE_W  last nonce inclusive, sampled on an accepted start.
REQ-010 nonce_ready  input  CORES  per-lane consumer ready.
REQ-011 nonce_valid  output  CORES  per-lane nonce available.
REQ-012 nonce_out  output  CORES*NONCE_W  lane i occupies bits [i*NONCE_W +: NONCE_W].
REQ-013 busy  output  1  high in RUN.
REQ-014 done  output  1  high in DONE.
REQ-015 success  output  1  high in DONE when the search ended by found.
REQ-016 issued_cnt  output  NONCE_W+1  count of completed transfers (valid&ready) this search.

Function
REQ-017 FSM states IDLE, RUN, DONE; start is accepted in IDLE or DONE and moves to RUN on the next edge.
REQ-018 On acceptance, lane i loads range_lo+i; nonce_valid[i] rises the cycle after start, only if range_lo+i <= range_hi.
REQ-019 Transfer on lane i when nonce_valid[i] & nonce_ready[i]; next lane value = current + CORES.
REQ-020 nonce_out and nonce_valid on a lane hold stable while valid & !ready.
REQ-021 Range compare uses NONCE_W+1-bit arithmetic; a lane whose next value exceeds range_hi or overflows NONCE_W deasserts valid after its final transfer; no wrap to 0.
REQ-022 With range_lo > range_hi: no valid is asserted; FSM goes RUN -> DONE in one cycle, success=0, issued_cnt=0.
REQ-023 RUN -> DONE with success=0 when every lane is exhausted.
REQ-024 found in RUN: all nonce_valid drop the next cycle; DONE with success=1; a transfer in the found cycle is counted.
REQ-025 Same-cycle final transfer and found: success=1.
REQ-026 abort in any state: next cycle IDLE, all valid low, done/success low; issued_cnt holds.
REQ-027 found outside RUN is ignored; start in RUN is ignored.
REQ-028 issued_cnt clears on accepted start and adds popcount(valid & ready) each cycle (up to CORES per cycle).
REQ-029 Each nonce in range is issued exactly once across all lanes.

Reset
REQ-030 n_rst low: state IDLE; nonce_valid, busy, done, success all 0; nonce_out 0; issued_cnt 0.
REQ-031 Reset asserted mid-search discards all in-flight nonces; no transfer completes in the reset cycle.

Structure
REQ-032 Package miner_pkg holds the FSM state enum and default NONCE_W constant.
REQ-033 Sub-module miner_nonce_lane (one per lane via generate): value register, valid, exhaust flag, range compare.
REQ-034 Top level holds FSM, issued_cnt adder, done/success logic.

Verification
REQ-035 CORES=4, lo=0x10, hi=0x1F, ready all 1 -> lanes issue 0x10..0x13 then +4 each; 4 transfers/cycle; done after 4 transfer cycles; issued_cnt=16, success=0.
REQ-036 CORES=4, lo=0x10, hi=0x12 -> lane 3 never valid; lanes 0..2 issue once; issued_cnt=3, done.
REQ-037 NONCE_W=8, lo=0xFC, hi=0xFF, CORES=4 -> single transfer per lane, no wrap to 0x00; issued_cnt=4.
REQ-038 Random nonce_ready backpressure, lo=0, hi=99 -> every value 0..99 seen exactly once; nonce_out stable while stalled.
REQ-039 found pulsed after 7 transfers -> valid low next cycle, done=1, success=1, issued_cnt=7; then abort -> IDLE, issued_cnt still 7.
REQ-040 lo=5, hi=4 -> no valid ever; done one cycle after RUN entry; n_rst pulse mid-RUN -> all outputs at reset values.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared types and constants for the nonce dispatcher.
package miner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NONCE_W_DEF = 32;

endpackage

// File: rtl/miner_nonce_lane.sv
// One dispatch lane: walks lo+LANE, lo+LANE+STEP, ... up to the sampled limit.
module miner_nonce_lane #(
  parameter int NONCE_W = 32,
  parameter int STEP    = 4,
  parameter int LANE    = 0
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               load,
  input  logic               clear,
  input  logic [NONCE_W-1:0] range_lo,
  input  logic [NONCE_W-1:0] range_hi,
  input  logic [NONCE_W-1:0] limit,
  input  logic               ready,
  output logic               valid,
  output logic [NONCE_W-1:0] value,
  output logic               exhaust
);

  localparam logic [NONCE_W:0] OFFSET = (NONCE_W+1)'(LANE);
  localparam logic [NONCE_W:0] STRIDE = (NONCE_W+1)'(STEP);

  logic [NONCE_W:0] first;
  logic [NONCE_W:0] next;
  logic             last;

  // The extra top bit catches overflow, so a lane can never wrap back to 0.
  assign first = {1'b0, range_lo} + OFFSET;
  assign next  = {1'b0, value} + STRIDE;
  assign last  = next > {1'b0, limit};

  // High when the lane holds no nonce after the coming edge.
  assign exhaust = ~valid | (ready & last);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      valid <= 1'b0;
      value <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      value <= first[NONCE_W-1:0];
      valid <= first <= {1'b0, range_hi};
    end else if (valid && ready) begin
      if (last) valid <= 1'b0;
      else      value <= next[NONCE_W-1:0];
    end
  end

endmodule

// File: rtl/miner_nonce_dispatcher.sv
// Splits a nonce range across CORES lanes; tracks search state and transfer count.
module miner_nonce_dispatcher
  import miner_pkg::*;
#(
  parameter int CORES   = 4,
  parameter int NONCE_W = NONCE_W_DEF
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       found,
  input  logic [NONCE_W-1:0]         range_lo,
  input  logic [NONCE_W-1:0]         range_hi,
  input  logic [CORES-1:0]           nonce_ready,
  output logic [CORES-1:0]           nonce_valid,
  output logic [CORES*NONCE_W-1:0]   nonce_out,
  output logic                       busy,
  output logic                       done,
  output logic                       success,
  output logic [NONCE_W:0]           issued_cnt
);

  state_t             state, state_nx;
  logic [CORES-1:0]   exhaust;
  logic [CORES-1:0]   xfer;
  logic [NONCE_W-1:0] hi_q;
  logic [NONCE_W:0]   xfer_cnt;
  logic               accept, kill, hit;

  // abort outranks start and found everywhere.
  assign accept = start & ~abort & (state != ST_RUN);
  assign kill   = abort | (found & (state == ST_RUN));
  assign xfer   = nonce_valid & nonce_ready;

  for (genvar i = 0; i < CORES; i++) begin : g_lane
    miner_nonce_lane #(
      .NONCE_W (NONCE_W),
      .STEP    (CORES),
      .LANE    (i)
    ) u_lane (
      .clk      (clk),
      .n_rst    (n_rst),
      .load     (accept),
      .clear    (kill),
      .range_lo (range_lo),
      .range_hi (range_hi),
      .limit    (hi_q),
      .ready    (nonce_ready[i]),
      .valid    (nonce_valid[i]),
      .value    (nonce_out[i*NONCE_W +: NONCE_W]),
      .exhaust  (exhaust[i])
    );
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (start) state_nx = ST_RUN;
        ST_RUN:           if (found || (&exhaust)) state_nx = ST_DONE;
        default:          state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    xfer_cnt = '0;
    for (int i = 0; i < CORES; i++) xfer_cnt = xfer_cnt + (NONCE_W+1)'(xfer[i]);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hi_q       <= '0;
      issued_cnt <= '0;
      hit        <= 1'b0;
    end else begin
      if (accept) hi_q <= range_hi;
      issued_cnt <= accept ? '0 : issued_cnt + xfer_cnt;
      // A found in RUN wins even when it coincides with the last transfer.
      if (abort || accept)                 hit <= 1'b0;
      else if (found && state == ST_RUN)   hit <= 1'b1;
    end
  end

  assign busy    = (state == ST_RUN);
  assign done    = (state == ST_DONE);
  assign success = done & hit;

endmodule
